clk_rate_monitor: RTL and testbench

CLK_RATE_MONITOR -- requirements
Module: clk_rate_monitor

---
 rtl/clk_rate_monitor.sv | 166 ++++++++++++++++
 tb/tb_clk_rate_monitor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rate_monitor.sv
// Measures the high/low phase durations of a clk-synchronous monitored clock and checks them.
// Optional stall detection is enabled by defining CLK_RATE_MONITOR_STUCK_DETECT_EN.
module clk_rate_monitor #(
    parameter int RATE_W     = 16,
    parameter int LOCK_COUNT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              monitor_en_i,
    input  logic              mon_clk_i,
    input  logic [RATE_W-1:0] expected_high_i,
    input  logic [RATE_W-1:0] expected_low_i,
    input  logic [RATE_W-1:0] tolerance_i,
    input  logic              mismatch_clear_i,
    output logic [RATE_W-1:0] measured_high_o,
    output logic [RATE_W-1:0] measured_low_o,
    output logic              measure_valid_o,
    output logic              mismatch_o,
    output logic              locked_o,
    output logic              stuck_o
);

    localparam int STREAK_W = $clog2(LOCK_COUNT + 1);
    localparam logic [RATE_W-1:0]   CNT_MAX  = '1;
    localparam logic [STREAK_W-1:0] LOCK_VAL = STREAK_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    state_t              state;
    state_t              next_state;
    logic                mon_prev;
    logic [RATE_W-1:0]   counter;
    logic [STREAK_W-1:0] streak;

    logic rise;
    logic fall;
    logic active;
    logic in_meas;
    logic load;
    logic cap_high;
    logic cap_low;
    logic bad;

    logic [RATE_W:0] meas_h;
    logic [RATE_W:0] meas_l;
    logic [RATE_W:0] exp_h;
    logic [RATE_W:0] exp_l;
    logic [RATE_W:0] diff_h;
    logic [RATE_W:0] diff_l;
    logic [RATE_W:0] tol;

    assign rise = mon_clk_i & ~mon_prev;
    assign fall = ~mon_clk_i & mon_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (clk_en) begin
            if (!monitor_en_i) begin
                next_state = IDLE;
            end else begin
                unique case (state)
                    IDLE:      next_state = ALIGN;
                    ALIGN:     if (rise) next_state = MEAS_HIGH;
                    MEAS_HIGH: if (fall) next_state = MEAS_LOW;
                    MEAS_LOW:  if (rise) next_state = MEAS_HIGH;
                    default:   next_state = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        active   = clk_en & monitor_en_i;
        in_meas  = (state == MEAS_HIGH) | (state == MEAS_LOW);
        load     = active & (state != IDLE) & (rise | fall);
        cap_high = active & (state == MEAS_HIGH) & fall;
        cap_low  = active & (state == MEAS_LOW) & rise;
    end

    // The low phase ends at the rise, so its length is the live counter.
    assign meas_h = {1'b0, measured_high_o};
    assign meas_l = {1'b0, counter};
    assign exp_h  = {1'b0, expected_high_i};
    assign exp_l  = {1'b0, expected_low_i};
    assign tol    = {1'b0, tolerance_i};
    assign diff_h = (meas_h >= exp_h) ? meas_h - exp_h : exp_h - meas_h;
    assign diff_l = (meas_l >= exp_l) ? meas_l - exp_l : exp_l - meas_l;
    assign bad    = cap_low & ((diff_h > tol) | (diff_l > tol));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_prev        <= 1'b0;
            counter         <= '0;
            streak          <= '0;
            measured_high_o <= '0;
            measured_low_o  <= '0;
            measure_valid_o <= 1'b0;
            mismatch_o      <= 1'b0;
        end else begin
            measure_valid_o <= cap_low;
            if (clk_en) begin
                mon_prev <= mon_clk_i;
                if (!monitor_en_i) begin
                    counter <= '0;
                end else if (load) begin
                    counter <= RATE_W'(1);
                end else if (in_meas && counter != CNT_MAX) begin
                    counter <= counter + RATE_W'(1);
                end
                if (cap_high) begin
                    measured_high_o <= counter;
                end
                if (cap_low) begin
                    measured_low_o <= counter;
                end
                if (!monitor_en_i || bad) begin
                    streak <= '0;
                end else if (cap_low && streak != LOCK_VAL) begin
                    streak <= streak + STREAK_W'(1);
                end
                if (bad) begin
                    mismatch_o <= 1'b1;
                end else if (mismatch_clear_i) begin
                    mismatch_o <= 1'b0;
                end
            end
        end
    end

`ifdef CLK_RATE_MONITOR_STUCK_DETECT_EN
    logic stuck_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuck_q <= 1'b0;
        end else if (clk_en) begin
            if (!monitor_en_i || rise || fall) begin
                stuck_q <= 1'b0;
            end else if (in_meas && counter == CNT_MAX) begin
                stuck_q <= 1'b1;
            end
        end
    end

    assign stuck_o  = stuck_q;
    assign locked_o = (streak == LOCK_VAL) & ~stuck_q;
`else
    assign stuck_o  = 1'b0;
    assign locked_o = (streak == LOCK_VAL);
`endif

endmodule

// File: tb/tb_clk_rate_monitor.sv
// Directed table-driven bench for clk_rate_monitor plus hand-written corner sequences.
module tb_clk_rate_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        monitor_en;
    logic        mon_clk;
    logic [15:0] exp_high;
    logic [15:0] exp_low;
    logic [15:0] tol;
    logic        mm_clear;
    logic [15:0] meas_high;
    logic [15:0] meas_low;
    logic        valid;
    logic        mismatch;
    logic        locked;
    logic        stuck;

    logic        clk_en4;
    logic        monitor_en4;
    logic        mon_clk4;
    logic        mm_clear4;
    logic [3:0]  meas_high4;
    logic [3:0]  meas_low4;
    logic        valid4;
    logic        mismatch4;
    logic        locked4;
    logic        stuck4;

    int pass_cnt = 0;
    int total    = 0;
    int vcount   = 0;

`ifdef CLK_RATE_MONITOR_STUCK_DETECT_EN
    localparam int STUCK_EN = 1;
`else
    localparam int STUCK_EN = 0;
`endif

    always #5 clk = ~clk;

    clk_rate_monitor #(.RATE_W(16), .LOCK_COUNT(2)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .monitor_en_i(monitor_en), .mon_clk_i(mon_clk),
        .expected_high_i(exp_high), .expected_low_i(exp_low),
        .tolerance_i(tol), .mismatch_clear_i(mm_clear),
        .measured_high_o(meas_high), .measured_low_o(meas_low),
        .measure_valid_o(valid), .mismatch_o(mismatch),
        .locked_o(locked), .stuck_o(stuck)
    );

    clk_rate_monitor #(.RATE_W(4), .LOCK_COUNT(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en4),
        .monitor_en_i(monitor_en4), .mon_clk_i(mon_clk4),
        .expected_high_i(4'd3), .expected_low_i(4'd3),
        .tolerance_i(4'd0), .mismatch_clear_i(mm_clear4),
        .measured_high_o(meas_high4), .measured_low_o(meas_low4),
        .measure_valid_o(valid4), .mismatch_o(mismatch4),
        .locked_o(locked4), .stuck_o(stuck4)
    );

    typedef struct {
        int eh; int el; int tl;
        int h;  int l;  int n;
        int wh; int wl; int wmm; int wlk;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input longint act, input longint want);
        total++;
        if (act == want) pass_cnt++;
        else $display("FAIL %s: got %0d, want %0d", name, act, want);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            if (valid) vcount++;
        end
    endtask

    task automatic ecyc();
        clk_en = 1'b1;
        @(negedge clk);
        clk_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid) begin
                found = 1'b1;
                break;
            end
        end
        chk(name, found, 1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        monitor_en = 1'b0;
        mm_clear   = 1'b1;
        cyc(1);
        mm_clear   = 1'b0;
        monitor_en = 1'b1;
        exp_high   = 16'(v.eh);
        exp_low    = 16'(v.el);
        tol        = 16'(v.tl);
        mon_clk    = 1'b0;
        cyc(2);
        for (int p = 0; p < v.n; p++) begin
            mon_clk = 1'b1;
            cyc(v.h);
            mon_clk = 1'b0;
            cyc(v.l);
        end
        mon_clk = 1'b1;
        wait_valid({name, "_valid"});
        chk({name, "_high"}, meas_high, v.wh);
        chk({name, "_low"}, meas_low, v.wl);
        chk({name, "_mismatch"}, mismatch, v.wmm);
        chk({name, "_locked"}, locked, v.wlk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3, 5, 0, 3, 5, 2, 3, 5, 0, 1};
        vecs[1] = '{3, 5, 0, 3, 5, 1, 3, 5, 0, 0};
        vecs[2] = '{5, 5, 1, 3, 5, 1, 3, 5, 1, 0};
        vecs[3] = '{4, 4, 1, 3, 5, 2, 3, 5, 0, 1};
        vecs[4] = '{10, 2, 0, 10, 2, 3, 10, 2, 0, 1};
        vecs[5] = '{2, 2, 0, 2, 3, 1, 2, 3, 1, 0};
        vecs[6] = '{1, 1, 0, 1, 1, 2, 1, 1, 0, 1};
        vecs[7] = '{0, 0, 65535, 7, 9, 2, 7, 9, 0, 1};
        vecs[8] = '{65535, 65535, 0, 2, 2, 1, 2, 2, 1, 0};

        rst_n = 1'b0; clk_en = 1'b1; monitor_en = 1'b0; mon_clk = 1'b0;
        exp_high = '0; exp_low = '0; tol = '0; mm_clear = 1'b0;
        clk_en4 = 1'b1; monitor_en4 = 1'b0; mon_clk4 = 1'b0; mm_clear4 = 1'b0;
        cyc(2);
        chk("rst_high", meas_high, 0);
        chk("rst_low", meas_low, 0);
        chk("rst_valid", valid, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_locked", locked, 0);
        chk("rst_stuck", stuck, 0);
        rst_n = 1'b1;
        cyc(1);

        // Narrow counter: saturation and stall detection.
        monitor_en4 = 1'b1;
        cyc(2);
        for (int p = 0; p < 2; p++) begin
            mon_clk4 = 1'b1;
            cyc(3);
            mon_clk4 = 1'b0;
            cyc(3);
        end
        mon_clk4 = 1'b1;
        cyc(1);
        chk("sat_locked_before", locked4, 1);
        cyc(19);
        chk("sat_stuck", stuck4, STUCK_EN);
        chk("sat_locked", locked4, 1 - STUCK_EN);
        mon_clk4 = 1'b0;
        cyc(1);
        chk("sat_high15", meas_high4, 15);
        chk("sat_stuck_clear", stuck4, 0);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        mm_clear = 1'b1;
        cyc(1);
        mm_clear = 1'b0;
        chk("clear_mismatch", mismatch, 0);

        run_vec(vecs[2], "bad_again");
        mm_clear = 1'b1;
        cyc(1);
        mm_clear = 1'b0;
        chk("clear_again", mismatch, 0);
        mon_clk = 1'b0;
        cyc(5);
        mon_clk  = 1'b1;
        mm_clear = 1'b1;
        wait_valid("clr_vs_set_valid");
        mm_clear = 1'b0;
        chk("clr_vs_set_mismatch", mismatch, 1);
        chk("clr_vs_set_locked", locked, 0);

        run_vec(vecs[0], "lock");
        monitor_en = 1'b0;
        cyc(1);
        chk("dis_locked", locked, 0);
        chk("dis_high_kept", meas_high, 3);
        chk("dis_low_kept", meas_low, 5);
        run_vec(vecs[0], "relock");

        // Disabled clk_en cycles must not be counted.
        monitor_en = 1'b0;
        cyc(1);
        monitor_en = 1'b1;
        mon_clk    = 1'b0;
        cyc(2);
        mon_clk = 1'b1;
        repeat (6) ecyc();
        mon_clk = 1'b0;
        repeat (4) ecyc();
        chk("clken_high", meas_high, 6);
        mon_clk = 1'b1;
        ecyc();
        chk("clken_low", meas_low, 4);
        clk_en = 1'b1;

        // Reset mid low phase, released with the monitored clock high.
        run_vec(vecs[0], "pre_rst");
        mon_clk = 1'b0;
        cyc(2);
        rst_n = 1'b0;
        #1;
        chk("midrst_high", meas_high, 0);
        chk("midrst_low", meas_low, 0);
        chk("midrst_mismatch", mismatch, 0);
        chk("midrst_locked", locked, 0);
        mon_clk = 1'b1;
        @(negedge clk);
        rst_n  = 1'b1;
        vcount = 0;
        cyc(2);
        mon_clk = 1'b0;
        cyc(5);
        mon_clk = 1'b1;
        cyc(3);
        mon_clk = 1'b0;
        cyc(5);
        chk("midrst_no_early_valid", vcount, 0);
        mon_clk = 1'b1;
        wait_valid("midrst_valid");
        chk("midrst_high_new", meas_high, 3);
        chk("midrst_low_new", meas_low, 5);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
